// File: rtl/ibex_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_MULL  = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam int unsigned MD_ITERATIONS = 32;

  // MULHU and REMU deliver the upper/remainder register, MULL and DIVU the q register.
  function automatic logic md_result_hi(input md_op_e op);
    return (op == MD_MULHU) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/ibex_multdiv_seq_if.sv
// Request/response bundle between the pipeline and the sequential multdiv unit.
interface ibex_multdiv_seq_if
  import ibex_pkg::*;
();
  logic        req_i;
  md_op_e      op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        kill_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  modport master (
    output req_i, op_i, operand_a_i, operand_b_i, kill_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  req_i, op_i, operand_a_i, operand_b_i, kill_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/ibex_multdiv_seq.sv
// Sequential unsigned multiply (shift-add) / divide (restoring) unit.
// Uses the external ALU adder, 32 iterations per operation.
// Optional: IBEX_MULTDIV_ZERO_BYPASS_EN finishes b==0 operations without iterating.
module ibex_multdiv_seq
  import ibex_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  ibex_multdiv_seq_if.slave md,
  output logic              alu_en_o,
  output logic [32:0]       alu_operand_a_o,
  output logic [32:0]       alu_operand_b_o,
  input  logic [33:0]       alu_adder_ext_i
);

  md_state_e   state, state_next;
  md_op_e      op;
  logic [4:0]  cnt;
  logic [31:0] op_b;
  logic [31:0] hi;      // multiply accumulator or division remainder
  logic [31:0] q;
  logic [31:0] result;
  logic [31:0] hi_step, q_step;
  logic [32:0] s;
  logic        ok;
  logic        is_div;
  logic        accept;
  logic        bypass;
  logic [31:0] bypass_result;
  logic        unused_ext0;

  assign accept      = (state == MD_IDLE) && md.req_i && !md.kill_i;
  assign is_div      = (op == MD_DIVU) || (op == MD_REMU);
  assign unused_ext0 = alu_adder_ext_i[0];

  // Zero-divisor shortcut: results match what the iteration would produce.
  always_comb begin
    bypass        = 1'b0;
    bypass_result = '0;
`ifdef IBEX_MULTDIV_ZERO_BYPASS_EN
    bypass = accept && (md.operand_b_i == '0);
    case (md.op_i)
      MD_DIVU: bypass_result = '1;
      MD_REMU: bypass_result = md.operand_a_i;
      default: bypass_result = '0;
    endcase
`endif
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= MD_IDLE;
    else       state <= state_next;
  end

  // Next state and handshake outputs; kill overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (accept) state_next = bypass ? MD_DONE : MD_CALC;
      MD_CALC: if (cnt == '0) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (md.kill_i) state_next = MD_IDLE;
    md.busy_o  = (state != MD_IDLE);
    md.valid_o = (state == MD_DONE) && !md.kill_i;
    alu_en_o   = (state == MD_CALC);
  end

  // One iteration step: ALU operand formatting and next register values
  always_comb begin
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    s               = {hi, q[31]};
    ok              = 1'b0;
    hi_step         = hi;
    q_step          = q;
    if (state == MD_CALC) begin
      if (is_div) begin
        // Trailing 1s make the adder compute s - b; ext[33] is the no-borrow flag.
        alu_operand_a_o = {s[31:0], 1'b1};
        alu_operand_b_o = {~op_b, 1'b1};
        ok              = s[32] | alu_adder_ext_i[33];
        hi_step         = ok ? alu_adder_ext_i[32:1] : s[31:0];
        q_step          = {q[30:0], ok};
      end else begin
        alu_operand_a_o    = {hi, 1'b1};
        alu_operand_b_o    = {(q[0] ? op_b : 32'h0), 1'b0};
        {hi_step, q_step}  = {alu_adder_ext_i[33], alu_adder_ext_i[32:1], q[31:1]};
      end
    end
  end

  // Operand capture on accept, one step per CALC cycle, result on entry to DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op     <= MD_MULL;
      op_b   <= '0;
      hi     <= '0;
      q      <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op   <= md.op_i;
      op_b <= md.operand_b_i;
      hi   <= '0;
      q    <= md.operand_a_i;
      cnt  <= 5'(MD_ITERATIONS - 1);
      if (bypass) result <= bypass_result;
    end else if ((state == MD_CALC) && !md.kill_i) begin
      hi  <= hi_step;
      q   <= q_step;
      cnt <= cnt - 5'd1;
      if (cnt == '0) result <= md_result_hi(op) ? hi_step : q_step;
    end
  end

  assign md.result_o = result;

endmodule
